// File: rtl/piso_tx_ctrl.sv
// Serial-transmit controller: accepts parallel words over valid/ready and shifts them out
// MSB-first on each sclk_en tick, framed with sof/eof and separated by a programmable idle gap.
module piso_tx_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned GAP      = 1,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sclk_en,
  output logic         sdo,
  output logic         sdo_valid,
  output logic         sof,
  output logic         eof,
  output logic         busy
);

  localparam int unsigned CW       = $clog2(N);
  localparam int unsigned GW       = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_LOAD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [GW-1:0] gapcnt_q, gapcnt_d;
  // Holds in_ready low until the first edge after reset release.
  logic          init_q, init_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      init_q   <= init_d;
    end
  end

  // Outputs decode only flopped state, except the GAP==0 word-boundary ready which follows sclk_en.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    gapcnt_d  = gapcnt_q;
    init_d    = 1'b1;
    in_ready  = 1'b0;
    sdo       = IDLE_LVL;
    sdo_valid = 1'b0;
    sof       = 1'b0;
    eof       = 1'b0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        in_ready = init_q;
        if (in_valid && init_q) begin
          shreg_d  = in_data;
          bitcnt_d = LAST_BIT;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sdo       = shreg_q[N-1];
        sdo_valid = 1'b1;
        sof       = (bitcnt_q == LAST_BIT);
        eof       = (bitcnt_q == '0);
        if ((GAP == 0) && (bitcnt_q == '0)) begin
          in_ready = sclk_en;
        end
        if (sclk_en) begin
          if (bitcnt_q != '0) begin
            shreg_d  = {shreg_q[N-2:0], 1'b0};
            bitcnt_d = bitcnt_q - CW'(1);
          end else if (GAP > 0) begin
            gapcnt_d = GAP_INIT;
            state_d  = S_GAP;
          end else if (in_valid) begin
            // Back-to-back streaming: next word replaces the finished one with no bubble.
            shreg_d  = in_data;
            bitcnt_d = LAST_BIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (sclk_en) begin
          if (gapcnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            gapcnt_d = gapcnt_q - GW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: three instances (GAP=1/IDLE=0, GAP=0/IDLE=0, GAP=2/IDLE=1) checked
// every cycle against a bit-queue reference model driven by directed and random producers.
module tb_piso_tx_ctrl;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;
  logic sclk_en;
  logic [N-1:0] in_data [3];
  logic in_valid  [3];
  logic in_ready  [3];
  logic sdo       [3];
  logic sdo_valid [3];
  logic sof       [3];
  logic eof       [3];
  logic busy      [3];

  int ncmp;
  int nerr;
  int cyc;
  int vprob;

  // Reference model: a FIFO of pending bits {bit, first, last} plus remaining idle ticks.
  logic [2:0] mq [3][0:63];
  int mh [3];
  int mt [3];
  int gap_left [3];
  bit rdy_ok [3];

  // Producer word lists.
  logic [N-1:0] src [3][0:15];
  int src_n [3];
  int src_i [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_tx_ctrl #(.N(N), .GAP(1), .IDLE_LVL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sclk_en(sclk_en), .sdo(sdo[0]), .sdo_valid(sdo_valid[0]), .sof(sof[0]), .eof(eof[0]),
    .busy(busy[0]));

  piso_tx_ctrl #(.N(N), .GAP(0), .IDLE_LVL(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sclk_en(sclk_en), .sdo(sdo[1]), .sdo_valid(sdo_valid[1]), .sof(sof[1]), .eof(eof[1]),
    .busy(busy[1]));

  piso_tx_ctrl #(.N(N), .GAP(2), .IDLE_LVL(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .sclk_en(sclk_en), .sdo(sdo[2]), .sdo_valid(sdo_valid[2]), .sof(sof[2]), .eof(eof[2]),
    .busy(busy[2]));

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  function automatic logic idle_of(input int i);
    return (i == 2) ? 1'b1 : 1'b0;
  endfunction

  function automatic int cnt(input int i);
    return mt[i] - mh[i];
  endfunction

  function automatic logic exp_ready(input int i);
    if (cnt(i) == 0 && gap_left[i] == 0) return rdy_ok[i];
    return (cnt(i) == 1 && gap_of(i) == 0) ? sclk_en : 1'b0;
  endfunction

  task automatic model_reset(input int i);
    mh[i] = 0;
    mt[i] = 0;
    gap_left[i] = 0;
    rdy_ok[i] = 1'b0;
  endtask

  task automatic push_word(input int i, input logic [N-1:0] w);
    for (int b = N - 1; b >= 0; b--) begin
      mq[i][6'(mt[i])] = {w[b], 1'(b == N - 1), 1'(b == 0)};
      mt[i]++;
    end
    src_i[i]++;
  endtask

  task automatic model_step(input int i);
    logic r;
    logic last;
    if (!rst) begin
      model_reset(i);
    end else begin
      r = exp_ready(i);
      if (cnt(i) > 0) begin
        if (sclk_en) begin
          last = mq[i][6'(mh[i])][0];
          mh[i]++;
          if (last) begin
            if (gap_of(i) > 0) gap_left[i] = gap_of(i);
            else if (in_valid[i] && r) push_word(i, in_data[i]);
          end
        end
      end else if (gap_left[i] > 0) begin
        if (sclk_en) gap_left[i]--;
      end else if (in_valid[i] && r) begin
        push_word(i, in_data[i]);
      end
      rdy_ok[i] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] observed=%b expected=%b cyc=%0d", tag, i, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic [2:0] f;
    for (int i = 0; i < 3; i++) begin
      f = (cnt(i) > 0) ? mq[i][6'(mh[i])] : {idle_of(i), 2'b00};
      chk("sdo", i, sdo[i], f[2]);
      chk("sdo_valid", i, sdo_valid[i], 1'(cnt(i) > 0));
      chk("sof", i, sof[i], f[1]);
      chk("eof", i, eof[i], f[0]);
      chk("busy", i, busy[i], 1'(cnt(i) > 0 || gap_left[i] > 0));
      chk("in_ready", i, in_ready[i], exp_ready(i));
    end
  endtask

  // period 0 = random tick; otherwise tick every period-th cycle.
  task automatic drive(input int period);
    for (int i = 0; i < 3; i++) begin
      if (src_i[i] < src_n[i] && int'($urandom_range(99)) < vprob) begin
        in_valid[i] = 1'b1;
        in_data[i]  = src[i][src_i[i]];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i]  = N'($urandom);
      end
    end
    sclk_en = (period == 0) ? 1'($urandom_range(1)) : 1'((cyc % period) == 0);
  endtask

  task automatic cycle(input int period);
    drive(period);
    #1;
    check_all();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int ncyc, input int period);
    for (int k = 0; k < ncyc; k++) cycle(period);
  endtask

  // Asserts reset a few ns after an edge and checks that outputs idle without waiting for clk.
  task automatic cycle_abort(input int period);
    drive(period);
    #1;
    check_all();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    check_all();
    @(negedge clk);
    cyc++;
  endtask

  task automatic new_phase();
    for (int i = 0; i < 3; i++) begin
      src_n[i] = 0;
      src_i[i] = 0;
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    cyc = 0;
    vprob = 100;
    rst = 1'b0;
    sclk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      model_reset(i);
    end
    new_phase();
    @(negedge clk);
    run(3, 1);
    rst = 1'b1;

    // Single word, GAP=0 streaming pair, and an IDLE_LVL=1 pair, ticking every clk.
    new_phase();
    src[0][0] = 8'hA5; src_n[0] = 1;
    src[1][0] = 8'hF0; src[1][1] = 8'h0F; src_n[1] = 2;
    src[2][0] = 8'hA5; src[2][1] = 8'h3C; src_n[2] = 2;
    run(30, 1);

    // Slow tick with a second word held valid during SHIFT (backpressure).
    new_phase();
    src[0][0] = 8'h81; src[0][1] = 8'h7E; src_n[0] = 2;
    src[1][0] = 8'h81; src[1][1] = 8'h55; src_n[1] = 2;
    src[2][0] = 8'h81; src_n[2] = 1;
    run(90, 4);

    // Mid-word reset abort; the partial word must not reappear.
    new_phase();
    for (int i = 0; i < 3; i++) begin
      src[i][0] = 8'hC3;
      src_n[i] = 1;
    end
    run(4, 1);
    cycle_abort(1);
    run(2, 1);
    rst = 1'b1;
    run(20, 1);

    // Random words, random valid and random ticks.
    new_phase();
    vprob = 60;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 12; k++) src[i][k] = N'($urandom);
      src_n[i] = 12;
    end
    run(400, 0);

    // Random words at full rate, then a long freeze between rare ticks.
    new_phase();
    vprob = 80;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 12; k++) src[i][k] = N'($urandom);
      src_n[i] = 12;
    end
    run(200, 1);
    new_phase();
    for (int i = 0; i < 3; i++) begin
      src[i][0] = N'($urandom);
      src_n[i] = 1;
    end
    run(120, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
